// File: rtl/id_decode_stage_if.sv
// Handshake/bus bundle for id_decode_stage: upstream instruction side, downstream
// decoded-control side, plus flush and the illegal-opcode counter.
interface id_decode_stage_if #(
  parameter int ALUOP_W = 4,
  parameter int PC_W    = 32
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [31:0]        out_instr;
  logic               regwrite;
  logic               regdst;
  logic               alusrc;
  logic               branch;
  logic               branch_ne;
  logic               memwrite;
  logic               memtoreg;
  logic               jump;
  logic               link;
  logic [ALUOP_W-1:0] aluop;
  logic               illegal;
  logic [15:0]        illegal_cnt;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_instr,
           regwrite, regdst, alusrc, branch, branch_ne, memwrite, memtoreg,
           jump, link, aluop, illegal, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_instr,
           regwrite, regdst, alusrc, branch, branch_ne, memwrite, memtoreg,
           jump, link, aluop, illegal, illegal_cnt
  );
endinterface

// File: rtl/id_decode_stage.sv
// Registered main-decode stage with a 2-entry skid FIFO and saturating illegal-opcode counter.
// Define ID_DECODE_EXT_OPS_EN to also decode BNE, JAL, LB and SB.
module id_decode_stage #(
  parameter int ALUOP_W = 4,
  parameter int PC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  id_decode_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} count_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [31:0]        instr;
    logic               regwrite;
    logic               regdst;
    logic               alusrc;
    logic               branch;
    logic               branch_ne;
    logic               memwrite;
    logic               memtoreg;
    logic               jump;
    logic               link;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
  } entry_t;

  count_t      count, count_nxt;
  entry_t      slot0, slot1, incoming, head;
  logic        accept, pop, ready_int, valid_int;
  logic        load0_new, load0_shift, load1_new;
  logic [15:0] illegal_cnt;

  function automatic logic [ALUOP_W-1:0] op4(input logic [3:0] code);
    return ALUOP_W'(code);
  endfunction

  function automatic entry_t imm_op(input entry_t e, input logic [3:0] code);
    entry_t r;
    r          = e;
    r.regwrite = 1'b1;
    r.alusrc   = 1'b1;
    r.aluop    = op4(code);
    return r;
  endfunction

  function automatic entry_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    entry_t e;
    e       = '0;
    e.pc    = pc;
    e.instr = instr;
    case (instr[31:26])
      6'b000000: begin e.regwrite = 1'b1; e.regdst = 1'b1; e.aluop = op4(4'b1000); end
      6'b100011: begin e = imm_op(e, 4'b0100); e.memtoreg = 1'b1; end
      6'b101011: begin e.alusrc = 1'b1; e.memwrite = 1'b1; e.aluop = op4(4'b0100); end
      6'b000100: begin e.branch = 1'b1; e.aluop = op4(4'b1011); end
      6'b001000: e = imm_op(e, 4'b0100);
      6'b001001: e = imm_op(e, 4'b0101);
      6'b001010: e = imm_op(e, 4'b0110);
      6'b001011: e = imm_op(e, 4'b0111);
      6'b001100: e = imm_op(e, 4'b0000);
      6'b001110: e = imm_op(e, 4'b0001);
      6'b001111: e = imm_op(e, 4'b0010);
      6'b001101: e = imm_op(e, 4'b0011);
      6'b000010: begin e.jump = 1'b1; e.aluop = op4(4'b0100); end
`ifdef ID_DECODE_EXT_OPS_EN
      6'b000101: begin e.branch = 1'b1; e.branch_ne = 1'b1; e.aluop = op4(4'b1011); end
      6'b000011: begin e.jump = 1'b1; e.regwrite = 1'b1; e.link = 1'b1; e.aluop = op4(4'b0100); end
      6'b100000: begin e = imm_op(e, 4'b0100); e.memtoreg = 1'b1; end
      6'b101000: begin e.alusrc = 1'b1; e.memwrite = 1'b1; e.aluop = op4(4'b0100); end
`endif
      default:   begin e.aluop = '1; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  // in_ready comes straight from the state register so upstream never sees out_ready ripple through.
  assign ready_int = (count != FULL);
  assign valid_int = (count != EMPTY);
  assign accept    = bus.in_valid & ready_int;
  assign pop       = valid_int & bus.out_ready;
  assign incoming  = decode(bus.in_instr, bus.in_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= EMPTY;
    else     count <= count_nxt;
  end

  always_comb begin
    count_nxt   = count;
    load0_new   = 1'b0;
    load0_shift = 1'b0;
    load1_new   = 1'b0;
    case (count)
      EMPTY: if (accept) begin count_nxt = ONE; load0_new = 1'b1; end
      ONE: begin
        if (accept && pop)  load0_new = 1'b1;
        else if (accept)    begin count_nxt = FULL; load1_new = 1'b1; end
        else if (pop)       count_nxt = EMPTY;
      end
      FULL:  if (pop) begin count_nxt = ONE; load0_shift = 1'b1; end
      default: count_nxt = EMPTY;
    endcase
    // Flush wins over everything except a pop, which the downstream has already consumed.
    if (bus.flush) begin
      count_nxt   = EMPTY;
      load0_new   = 1'b0;
      load0_shift = 1'b0;
      load1_new   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (load0_new)        slot0 <= incoming;
      else if (load0_shift) slot0 <= slot1;
      if (load1_new)        slot1 <= incoming;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= '0;
    else if (accept && incoming.illegal && !bus.flush && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end

  assign head            = valid_int ? slot0 : '0;
  assign bus.in_ready    = ready_int;
  assign bus.out_valid   = valid_int;
  assign bus.out_pc      = head.pc;
  assign bus.out_instr   = head.instr;
  assign bus.regwrite    = head.regwrite;
  assign bus.regdst      = head.regdst;
  assign bus.alusrc      = head.alusrc;
  assign bus.branch      = head.branch;
  assign bus.memwrite    = head.memwrite;
  assign bus.memtoreg    = head.memtoreg;
  assign bus.jump        = head.jump;
  assign bus.aluop       = head.aluop;
  assign bus.illegal     = head.illegal;
  assign bus.illegal_cnt = illegal_cnt;

`ifdef ID_DECODE_EXT_OPS_EN
  assign bus.branch_ne   = head.branch_ne;
  assign bus.link        = head.link;
`else
  logic unused_ext;
  assign unused_ext      = head.branch_ne ^ head.link;
  assign bus.branch_ne   = 1'b0;
  assign bus.link        = 1'b0;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed, table-driven bench for id_decode_stage: decode table, back-pressure,
// flush, illegal counter saturation and asynchronous reset.
module tb_id_decode_stage;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;
  int   expCnt;

  id_decode_stage_if #(.ALUOP_W(4), .PC_W(32)) bus ();

  id_decode_stage #(.ALUOP_W(4), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed control view: regwrite,regdst,alusrc,branch,branch_ne,memwrite,memtoreg,jump,link,illegal,aluop
  logic [13:0] ctrl;
  assign ctrl = {bus.regwrite, bus.regdst, bus.alusrc, bus.branch, bus.branch_ne,
                 bus.memwrite, bus.memtoreg, bus.jump, bus.link, bus.illegal, bus.aluop};

  localparam logic [13:0] C_R    = {10'b1100000000, 4'b1000};
  localparam logic [13:0] C_LW   = {10'b1010001000, 4'b0100};
  localparam logic [13:0] C_SW   = {10'b0010010000, 4'b0100};
  localparam logic [13:0] C_BEQ  = {10'b0001000000, 4'b1011};
  localparam logic [9:0]  C_IMM  = 10'b1010000000;
  localparam logic [13:0] C_J    = {10'b0000000100, 4'b0100};
  localparam logic [13:0] C_ILL  = {10'b0000000001, 4'b1111};
  localparam logic [13:0] C_BNE  = {10'b0001100000, 4'b1011};
  localparam logic [13:0] C_JAL  = {10'b1000000110, 4'b0100};

  localparam logic [31:0] I_LW   = 32'h8C430004;
  localparam logic [31:0] I_BEQ  = 32'h10000003;
  localparam logic [31:0] I_ORI  = 32'h34000001;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  typedef struct {
    logic [31:0] instr;
    logic [13:0] ctrl;
  } vec_t;

  vec_t vecs [18];

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic ready, input logic fl);
    bus.in_valid  = valid;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ready;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, " in_ready"},  64'(bus.in_ready),  64'd1);
    checkOutput({tag, " ctrl"},      64'(ctrl),          64'd0);
    checkOutput({tag, " out_pc"},    64'(bus.out_pc),    64'd0);
    checkOutput({tag, " out_instr"}, 64'(bus.out_instr), 64'd0);
  endtask

  function automatic logic [13:0] extOr(input logic [13:0] c);
`ifdef ID_DECODE_EXT_OPS_EN
    return c;
`else
    return (c == 14'd0) ? C_ILL : C_ILL;
`endif
  endfunction

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expCnt      = 0;

    vecs[0]  = '{32'h00221820, C_R};
    vecs[1]  = '{I_LW,         C_LW};
    vecs[2]  = '{32'hAC430004, C_SW};
    vecs[3]  = '{I_BEQ,        C_BEQ};
    vecs[4]  = '{32'h20010005, {C_IMM, 4'b0100}};
    vecs[5]  = '{32'h24010005, {C_IMM, 4'b0101}};
    vecs[6]  = '{32'h28010005, {C_IMM, 4'b0110}};
    vecs[7]  = '{32'h2C010005, {C_IMM, 4'b0111}};
    vecs[8]  = '{32'h30010005, {C_IMM, 4'b0000}};
    vecs[9]  = '{I_ORI,        {C_IMM, 4'b0011}};
    vecs[10] = '{32'h38010005, {C_IMM, 4'b0001}};
    vecs[11] = '{32'h3C010005, {C_IMM, 4'b0010}};
    vecs[12] = '{32'h08000010, C_J};
    vecs[13] = '{I_ILL,        C_ILL};
    vecs[14] = '{32'h14000002, extOr(C_BNE)};
    vecs[15] = '{32'h0C000010, extOr(C_JAL)};
    vecs[16] = '{32'h80000000, extOr(C_LW)};
    vecs[17] = '{32'hA0000000, extOr(C_SW)};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    checkIdle("reset");
    checkOutput("reset illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    rst = 1'b0;

    // Single LW with 1-cycle latency, then drain.
    applyStimulus(1'b1, I_LW, 32'h100, 1'b1, 1'b0);
    step();
    checkOutput("lw out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("lw ctrl",      64'(ctrl),          64'(C_LW));
    checkOutput("lw out_pc",    64'(bus.out_pc),    64'h100);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkIdle("lw drain");

    // Three illegal opcodes back to back.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, I_ILL, 32'h200 + 32'(i * 4), 1'b1, 1'b0);
      step();
      expCnt++;
      checkOutput("ill ctrl",   64'(ctrl),          64'(C_ILL));
      checkOutput("ill out_pc", 64'(bus.out_pc),    64'(32'h200 + 32'(i * 4)));
    end
    checkOutput("ill cnt3", 64'(bus.illegal_cnt), 64'd3);

    // Decode table at full throughput.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
      step();
      if (vecs[i].ctrl[4]) expCnt++;
      checkOutput($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("vec%0d in_ready", i),  64'(bus.in_ready),  64'd1);
      checkOutput($sformatf("vec%0d ctrl", i),      64'(ctrl),          64'(vecs[i].ctrl));
      checkOutput($sformatf("vec%0d out_instr", i), 64'(bus.out_instr), 64'(vecs[i].instr));
      checkOutput($sformatf("vec%0d out_pc", i),    64'(bus.out_pc),    64'(32'h1000 + 32'(i * 4)));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkIdle("table drain");
    checkOutput("table illegal_cnt", 64'(bus.illegal_cnt), 64'(expCnt));

    // Back-pressure: LW, BEQ fill the buffer, ORI waits, then all three pop in order.
    applyStimulus(1'b1, I_LW, 32'h300, 1'b0, 1'b0);
    step();
    checkOutput("bp1 instr",    64'(bus.out_instr), 64'(I_LW));
    checkOutput("bp1 in_ready", 64'(bus.in_ready),  64'd1);
    applyStimulus(1'b1, I_BEQ, 32'h304, 1'b0, 1'b0);
    step();
    checkOutput("bp2 in_ready", 64'(bus.in_ready),  64'd0);
    checkOutput("bp2 instr",    64'(bus.out_instr), 64'(I_LW));
    applyStimulus(1'b1, I_ORI, 32'h308, 1'b0, 1'b0);
    step();
    checkOutput("bp3 in_ready", 64'(bus.in_ready),  64'd0);
    checkOutput("bp3 instr",    64'(bus.out_instr), 64'(I_LW));
    checkOutput("bp3 ctrl",     64'(ctrl),          64'(C_LW));
    applyStimulus(1'b1, I_ORI, 32'h308, 1'b1, 1'b0);
    step();
    checkOutput("bp4 instr",    64'(bus.out_instr), 64'(I_BEQ));
    checkOutput("bp4 ctrl",     64'(ctrl),          64'(C_BEQ));
    checkOutput("bp4 in_ready", 64'(bus.in_ready),  64'd1);
    step();
    checkOutput("bp5 instr",    64'(bus.out_instr), 64'(I_ORI));
    checkOutput("bp5 ctrl",     64'(ctrl),          64'({C_IMM, 4'b0011}));
    checkOutput("bp5 out_pc",   64'(bus.out_pc),    64'h308);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkIdle("bp drain");

    // Flush while FULL with a waiting illegal instruction.
    applyStimulus(1'b1, I_LW, 32'h400, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, I_ILL, 32'h404, 1'b0, 1'b0);
    step();
    expCnt++;
    checkOutput("fl full in_ready", 64'(bus.in_ready), 64'd0);
    applyStimulus(1'b1, I_ILL, 32'h408, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkIdle("flush full");
    checkOutput("flush full cnt", 64'(bus.illegal_cnt), 64'(expCnt));

    // Flush in ONE discards a same-cycle illegal accept without counting it.
    applyStimulus(1'b1, I_LW, 32'h500, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, I_ILL, 32'h504, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkIdle("flush one");
    checkOutput("flush one cnt", 64'(bus.illegal_cnt), 64'(expCnt));

    // Asynchronous reset mid-cycle while holding one entry.
    applyStimulus(1'b1, I_LW, 32'h600, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("arst pre valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    checkIdle("arst");
    checkOutput("arst cnt", 64'(bus.illegal_cnt), 64'd0);
    expCnt = 0;
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, I_BEQ, 32'h700, 1'b1, 1'b0);
    step();
    checkOutput("arst first accept valid", 64'(bus.out_valid), 64'd1);
    checkOutput("arst first accept ctrl",  64'(ctrl),          64'(C_BEQ));

    // Saturation of the illegal counter.
    applyStimulus(1'b1, I_ILL, 32'h800, 1'b1, 1'b0);
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    checkOutput("sat reach", 64'(bus.illegal_cnt), 64'hFFFF);
    step();
    checkOutput("sat hold", 64'(bus.illegal_cnt), 64'hFFFF);
    checkOutput("sat ctrl", 64'(ctrl),            64'(C_ILL));
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    checkIdle("final drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered main-decode stage between the IF/ID instruction register and the ID/EX pipeline register. It decodes the 6-bit opcode of each accepted instruction into the control bundle (regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop) plus an illegal-instruction flag. It buffers up to two decoded entries behind a valid/ready handshake so that `in_ready` never depends combinationally on `out_ready`. It supports pipeline flush and counts illegal opcodes for the exception/perf logic.

## Interface
- `ALUOP_W`, default 4: aluop width, must be ≥4; 4-bit codes are zero-extended, except the illegal code, which is all ones.
- `PC_W`, default 32: width of the PC carried alongside each instruction.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high. This is already decided.
- `flush` in 1: synchronous drop of all buffered entries.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_instr` in 32, `in_pc` in PC_W: instruction word and its PC.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_pc` out PC_W, `out_instr` out 32: head entry pass-through.
- `regwrite`, `regdst`, `alusrc`, `branch`, `branch_ne`, `memwrite`, `memtoreg`, `jump`, `link` out 1 each: head entry controls.
- `aluop` out ALUOP_W: head entry ALU operation.
- `illegal` out 1: head entry opcode is unrecognised.
- `illegal_cnt` out 16: saturating count of illegal opcodes accepted.

## Operation
- Decode uses `in_instr[31:26]` at accept time; the result is stored in the entry.
- Field order in each line: regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop.
  - 000000 R-type: 1,1,0,0,0,0,0,1000
  - 100011 LW: 1,0,1,0,0,1,0,0100
  - 101011 SW: 0,0,1,0,1,0,0,0100
  - 000100 BEQ: 0,0,0,1,0,0,0,1011
  - 001000 ADDI: 1,0,1,0,0,0,0,0100
  - 001001 ADDIU: aluop 0101, otherwise as ADDI
  - 001010 SLTI: aluop 0110, otherwise as ADDI
  - 001011 SLTIU: aluop 0111, otherwise as ADDI
  - 001100 ANDI: aluop 0000, otherwise as ADDI
  - 001110 XORI: aluop 0001, otherwise as ADDI
  - 001111 LUI: aluop 0010, otherwise as ADDI
  - 001101 ORI: aluop 0011, otherwise as ADDI
  - 000010 J: 0,0,0,0,0,0,1,0100
- `branch_ne` and `link` are 0 for all of the above.
- Any other opcode: all controls 0, `aluop` all ones, `illegal`=1.
- Buffer is a 2-entry FIFO with state `count` ∈ {EMPTY, ONE, FULL}.
  - accept = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
  - EMPTY --accept--> ONE.
  - ONE --accept & !pop--> FULL; ONE --pop & !accept--> EMPTY; accept & pop stays ONE.
  - FULL --pop--> ONE. No accept is possible while FULL.
- `in_ready` = (count != FULL), driven from registered state only.
- `out_valid` = (count != EMPTY). Outputs present the oldest entry and are all zero when `out_valid`=0.
- `flush` forces EMPTY at the next edge and discards a same-cycle accept. A same-cycle pop still completes downstream.
- `illegal_cnt` increments on each accept of an illegal opcode, unless `flush` is asserted that cycle. It saturates at 0xFFFF and is cleared only by `rst`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible at the outputs after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- Upstream may rely on `in_ready` being stable through the cycle. Downstream must hold `out_ready` combinationally independent of `out_valid`.
- Reset values: count EMPTY, `out_valid` 0, `in_ready` 1, all control outputs 0, `aluop` 0, `out_pc`/`out_instr` 0, `illegal_cnt` 0.
- `rst` asserted mid-stream drops all entries immediately (asynchronous). The first accept is possible on the first edge after release.
- Simultaneous accept and pop in FULL cannot occur. In ONE, accept and pop together keep ONE, with the new entry becoming the head.

## Configuration
- `ID_DECODE_EXT_OPS_EN` defined adds four opcodes:
  - 000101 BNE: as BEQ plus `branch_ne`=1.
  - 000011 JAL: as J plus regwrite=1, `link`=1.
  - 100000 LB: as LW.
  - 101000 SB: as SW.
- `ID_DECODE_EXT_OPS_EN` undefined: those four opcodes decode as illegal, and `branch_ne`/`link` are tied to 0.

## Test plan
- Reset, then drive 0x8C430004 (LW) with `out_ready`=1 → next cycle `out_valid`=1, regwrite=1, alusrc=1, memtoreg=1, aluop=0100, `illegal`=0.
- Hold `out_ready`=0 and drive LW, BEQ 0x10000003, ORI 0x34000001 on back-to-back cycles → `in_ready` drops after 2 accepts and ORI is held off. Raising `out_ready` then pops LW, BEQ (branch=1, aluop 1011), ORI in order with no loss or duplication.
- Drive 0xFC000000 three times → `illegal`=1 and aluop=1111 each time, `illegal_cnt`=3. Forcing the counter to 0xFFFF and accepting another illegal opcode keeps it at 0xFFFF.
- With count FULL, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, `illegal_cnt` unchanged.
- Drive 0x14000002 (BNE) and 0x0C000010 (JAL):
  - with `ID_DECODE_EXT_OPS_EN` defined → `branch_ne`=1 for BNE; jump=1, `link`=1, regwrite=1 for JAL.
  - without it → both decode as illegal.
- Assert `rst` asynchronously mid-cycle while in ONE → outputs go to reset values before the next edge.
